// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared definitions for the MEM stage of the RV32I pipeline.
//   - funct3 encodings for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - access size codes (funct3[1:0])
//   - MEM-stage FSM state encoding
//   - helpers for the effective byte lane and misalignment detection
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } mem_state_e;

  // Byte lane actually used for an access. Halves ignore a[0] and words
  // ignore a[1:0], so a misaligned address silently rounds down when the
  // trap is not built in.
  function automatic logic [1:0] eff_lane(input logic [2:0] funct3,
                                          input logic [1:0] addr_lo);
    case (funct3[1:0])
      SIZE_BYTE: return addr_lo;
      SIZE_HALF: return {addr_lo[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  // True when the low address bits do not match the access size.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
    case (funct3[1:0])
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align
//   Combinational load aligner: picks the addressed byte/half out of the raw
//   bus word and sign- or zero-extends it to 32 bits.
// Ports
//   rdata      in   32  raw word from the data bus
//   addr_lo    in   2   low effective-address bits
//   funct3     in   3   load size/sign (LB/LH/LW/LBU/LHU)
//   load_data  out  32  aligned, extended load value
module mem_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then extend according to funct3.
  always_comb begin
    lane      = eff_lane(funct3, addr_lo);
    shifted   = rdata >> {lane, 3'b000};
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
//   MEM stage of the 5-stage RV32I pipeline. Runs loads/stores on a
//   req/gnt/rvalid data bus from the held EX/MEM word, aligns load data and
//   registers the MEM/WB word. stall_out holds upstream while an access is
//   outstanding.
// Parameters
//   XLEN         datapath width (32 only)
//   BUS_TIMEOUT  cycles allowed in REQ+WAIT before abort; 0 disables the watchdog
// Build option
//   MISALIGN_TRAP_EN  when defined, misaligned LH/LHU/SH/LW/SW complete at once
//                     with misalign_trap=1 and no bus request; otherwise the
//                     offending low address bits are ignored.
// Ports
//   clk, rst                          clock, async active-high reset
//   ex_*                              EX/MEM word (held stable while stalled)
//   stall_out                         freeze IF..EX/MEM
//   dmem_req/we/addr/be/wdata         bus request side (zero when not requesting)
//   dmem_gnt/rvalid/rdata             bus response side
//   wb_*                              registered MEM/WB word
//   bus_err, misalign_trap            one-cycle pulses alongside wb_valid
module mem_access
  import riscv_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BUS_TIMEOUT = 0
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic            ex_wb_ctrl,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_alu_out,
  output logic [XLEN-1:0] wb_memory_read,
  output logic            wb_ctrl,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic            bus_err,
  output logic            misalign_trap
);

  localparam int TIMER_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);

  mem_state_e        state, state_next;
  logic [TIMER_W-1:0] timer;
  logic              mem_op;
  logic              trap;
  logic              timeout;
  logic              done;
  logic              stall;
  logic              commit;
  logic [1:0]        lane;
  logic [XLEN-1:0]   load_data;

  assign mem_op = ex_mem_read | ex_mem_write;
  assign lane   = eff_lane(ex_funct3, ex_alu_out[1:0]);

`ifdef MISALIGN_TRAP_EN
  assign trap = (state == ST_IDLE) & ex_valid & mem_op &
                is_misaligned(ex_funct3, ex_alu_out[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Watchdog fires in the BUS_TIMEOUT-th cycle spent in REQ/WAIT, unless the
  // access legitimately finishes in that same cycle. A load grant at the
  // limit is still aborted, since the data phase would overrun the budget.
  always_comb begin
    timeout = 1'b0;
    if (BUS_TIMEOUT != 0 && state != ST_IDLE &&
        timer == TIMER_W'(BUS_TIMEOUT - 1)) begin
      timeout = !((state == ST_REQ && dmem_gnt && ex_mem_write) ||
                  (state == ST_WAIT && dmem_rvalid));
    end
  end

  // Next-state logic. 'done' marks the cycle in which the memory op finishes,
  // so the stall drops and MEM/WB loads on the same edge. rvalid is only
  // honoured in WAIT, which discards stale responses after a reset.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    dmem_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        done = trap;
        if (ex_valid && mem_op && !trap) state_next = ST_REQ;
      end
      ST_REQ: begin
        dmem_req = !timeout;
        if (timeout) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else if (dmem_gnt) begin
          if (ex_mem_write) begin
            done       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (timeout || dmem_rvalid) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign stall     = ex_valid & mem_op & !done;
  assign stall_out = stall & !rst;
  assign commit    = ex_valid & !stall;

  // Bus request fields are only driven while a request is up so the bus
  // sees zeros when idle. Store data is replicated across every lane.
  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    if (dmem_req) begin
      dmem_we   = ex_mem_write;
      dmem_addr = {ex_alu_out[XLEN-1:2], 2'b00};
      case (ex_funct3[1:0])
        SIZE_BYTE: begin
          dmem_be    = 4'b0001 << lane;
          dmem_wdata = {4{ex_store_data[7:0]}};
        end
        SIZE_HALF: begin
          dmem_be    = 4'b0011 << lane;
          dmem_wdata = {2{ex_store_data[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = ex_store_data;
        end
      endcase
    end
  end

  mem_load_align u_load_align (
    .rdata     (dmem_rdata),
    .addr_lo   (ex_alu_out[1:0]),
    .funct3    (ex_funct3),
    .load_data (load_data)
  );

  // State register and watchdog timer; the timer restarts whenever the FSM
  // is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE) timer <= '0;
      else                  timer <= timer + TIMER_W'(1);
    end
  end

  // MEM/WB register. A stalled edge inserts a bubble; stores, aborts and
  // traps never write the register file.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid       <= 1'b0;
      wb_alu_out     <= '0;
      wb_memory_read <= '0;
      wb_ctrl        <= 1'b0;
      wb_rd          <= 5'd0;
      wb_reg_write   <= 1'b0;
      bus_err        <= 1'b0;
      misalign_trap  <= 1'b0;
    end else begin
      wb_valid       <= commit;
      wb_alu_out     <= ex_alu_out;
      wb_memory_read <= load_data;
      wb_ctrl        <= ex_wb_ctrl;
      wb_rd          <= ex_rd;
      wb_reg_write   <= commit & ex_reg_write & !ex_mem_write & !timeout & !trap;
      bus_err        <= commit & timeout;
      misalign_trap  <= commit & trap;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access
//   Directed self-checking bench for mem_access (watchdog set to 8 cycles).
module tb_mem_access;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_memory_read;
  logic        wb_ctrl;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        bus_err;
  logic        misalign_trap;

  int checks = 0;
  int errors = 0;
  int stallCycles;

  mem_access #(.XLEN(32), .BUS_TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_alu_out     (ex_alu_out),
    .ex_store_data  (ex_store_data),
    .ex_funct3      (ex_funct3),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_wb_ctrl     (ex_wb_ctrl),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .stall_out      (stall_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_gnt       (dmem_gnt),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_alu_out     (wb_alu_out),
    .wb_memory_read (wb_memory_read),
    .wb_ctrl        (wb_ctrl),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .bus_err        (bus_err),
    .misalign_trap  (misalign_trap)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Loads the EX/MEM word; write-back select follows the op type.
  task automatic applyStimulus(input logic valid, input logic [31:0] alu,
                               input logic [31:0] sdata, input logic [2:0] f3,
                               input logic rd_en, input logic wr_en,
                               input logic regw, input logic [4:0] rd);
    ex_valid      = valid;
    ex_alu_out    = alu;
    ex_store_data = sdata;
    ex_funct3     = f3;
    ex_mem_read   = rd_en;
    ex_mem_write  = wr_en;
    ex_wb_ctrl    = !(rd_en | wr_en);
    ex_reg_write  = regw;
    ex_rd         = rd;
  endtask

  // Sample point just after the active edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Load with immediate grant and rvalid in the first WAIT cycle.
  task automatic busLoad(input string tag, input logic [31:0] addr,
                         input logic [2:0] f3, input logic [31:0] rdata,
                         input logic [31:0] expData);
    applyStimulus(1'b1, addr, 32'h0, f3, 1'b1, 1'b0, 1'b1, 5'd7);
    tick;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick;
    dmem_rvalid = 1'b0;
    ex_valid    = 1'b0;
    checkOutput({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'h1);
    checkOutput({tag, "_data"}, wb_memory_read, expData);
  endtask

  initial begin
    rst         = 1'b1;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 32'h0;
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 5'd0);
    tick;
    tick;
    checkOutput("reset_req", {31'h0, dmem_req}, 32'h0);
    checkOutput("reset_stall", {31'h0, stall_out}, 32'h0);
    checkOutput("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("reset_wb_alu", wb_alu_out, 32'h0);
    rst = 1'b0;

    // 1: ALU op passes through with one-cycle latency.
    applyStimulus(1'b1, 32'h0000_1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    checkOutput("add_stall", {31'h0, stall_out}, 32'h0);
    tick;
    checkOutput("add_wb_valid", {31'h0, wb_valid}, 32'h1);
    checkOutput("add_wb_alu", wb_alu_out, 32'h0000_1234);
    checkOutput("add_wb_rd", {27'h0, wb_rd}, 32'd5);
    checkOutput("add_wb_ctrl", {31'h0, wb_ctrl}, 32'h1);
    ex_valid = 1'b0;
    tick;
    checkOutput("bubble_wb_valid", {31'h0, wb_valid}, 32'h0);

    // 2: LB at 0x103, gnt in cycle 1, rvalid in cycle 3.
    stallCycles = 0;
    applyStimulus(1'b1, 32'h0000_0103, 32'h0, F3_LB, 1'b1, 1'b0, 1'b1, 5'd3);
    #1;
    stallCycles += int'(stall_out);
    checkOutput("lb_idle_req", {31'h0, dmem_req}, 32'h0);
    tick;
    dmem_gnt = 1'b1;
    #1;
    stallCycles += int'(stall_out);
    checkOutput("lb_req", {31'h0, dmem_req}, 32'h1);
    checkOutput("lb_addr", dmem_addr, 32'h0000_0100);
    checkOutput("lb_be", {28'h0, dmem_be}, 32'h8);
    tick;
    dmem_gnt = 1'b0;
    checkOutput("lb_bubble", {31'h0, wb_valid}, 32'h0);
    #1;
    stallCycles += int'(stall_out);
    tick;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h80FF_0000;
    #1;
    stallCycles += int'(stall_out);
    tick;
    dmem_rvalid = 1'b0;
    ex_valid    = 1'b0;
    checkOutput("lb_stall_cycles", stallCycles, 32'd3);
    checkOutput("lb_wb_valid", {31'h0, wb_valid}, 32'h1);
    checkOutput("lb_data", wb_memory_read, 32'hFFFF_FF80);
    checkOutput("lb_regw", {31'h0, wb_reg_write}, 32'h1);

    // 3: SH at 0x102: upper half lanes, replicated data, no reg write.
    applyStimulus(1'b1, 32'h0000_0102, 32'h0000_ABCD, F3_SH, 1'b0, 1'b1, 1'b1, 5'd9);
    tick;
    dmem_gnt = 1'b1;
    #1;
    checkOutput("sh_we", {31'h0, dmem_we}, 32'h1);
    checkOutput("sh_be", {28'h0, dmem_be}, 32'hC);
    checkOutput("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    checkOutput("sh_done_stall", {31'h0, stall_out}, 32'h0);
    tick;
    dmem_gnt = 1'b0;
    ex_valid = 1'b0;
    checkOutput("sh_wb_valid", {31'h0, wb_valid}, 32'h1);
    checkOutput("sh_regw", {31'h0, wb_reg_write}, 32'h0);

    // SB at 0x101: single lane 1, byte replicated four times.
    applyStimulus(1'b1, 32'h0000_0101, 32'h1234_565A, F3_SB, 1'b0, 1'b1, 1'b0, 5'd0);
    tick;
    dmem_gnt = 1'b1;
    #1;
    checkOutput("sb_be", {28'h0, dmem_be}, 32'h2);
    checkOutput("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
    tick;
    dmem_gnt = 1'b0;
    ex_valid = 1'b0;

    // Half loads: lane 2 sign-extended, lane 2 zero-extended.
    busLoad("lh", 32'h0000_0106, F3_LH, 32'h8001_0000, 32'hFFFF_8001);
    busLoad("lhu", 32'h0000_0106, F3_LHU, 32'h8001_0000, 32'h0000_8001);
    busLoad("lbu", 32'h0000_0101, F3_LBU, 32'h0000_9600, 32'h0000_0096);

    // 4: LW with grant withheld for five REQ cycles.
    applyStimulus(1'b1, 32'h0000_0200, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 5'd4);
    tick;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("lw_hold_req%0d", i), {31'h0, dmem_req}, 32'h1);
      checkOutput($sformatf("lw_hold_stall%0d", i), {31'h0, stall_out}, 32'h1);
      tick;
    end
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    #1;
    checkOutput("lw_rvalid_stall", {31'h0, stall_out}, 32'h0);
    tick;
    dmem_rvalid = 1'b0;
    ex_valid    = 1'b0;
    checkOutput("lw_data", wb_memory_read, 32'hDEAD_BEEF);
    checkOutput("lw_bus_err", {31'h0, bus_err}, 32'h0);

    // Watchdog: no grant at all; aborts in the 8th REQ cycle.
    applyStimulus(1'b1, 32'h0000_0400, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 5'd6);
    tick;
    for (int i = 0; i < 7; i++) tick;
    checkOutput("wd_req_drop", {31'h0, dmem_req}, 32'h0);
    checkOutput("wd_stall_drop", {31'h0, stall_out}, 32'h0);
    tick;
    ex_valid = 1'b0;
    checkOutput("wd_bus_err", {31'h0, bus_err}, 32'h1);
    checkOutput("wd_wb_valid", {31'h0, wb_valid}, 32'h1);
    checkOutput("wd_regw", {31'h0, wb_reg_write}, 32'h0);
    tick;
    checkOutput("wd_bus_err_pulse", {31'h0, bus_err}, 32'h0);

    // 5a: reset while requesting drops dmem_req immediately.
    applyStimulus(1'b1, 32'h0000_0300, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 5'd2);
    tick;
    checkOutput("rst_req_before", {31'h0, dmem_req}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("rst_req_drop", {31'h0, dmem_req}, 32'h0);
    checkOutput("rst_stall_drop", {31'h0, stall_out}, 32'h0);
    ex_valid = 1'b0;
    tick;
    rst = 1'b0;

    // 5b: reset in WAIT; a late rvalid must not produce a write-back.
    applyStimulus(1'b1, 32'h0000_0304, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 5'd2);
    tick;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_wait_wb_valid", {31'h0, wb_valid}, 32'h0);
    ex_valid = 1'b0;
    tick;
    rst         = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    tick;
    dmem_rvalid = 1'b0;
    checkOutput("stale_rvalid_wb_valid", {31'h0, wb_valid}, 32'h0);
    checkOutput("stale_rvalid_regw", {31'h0, wb_reg_write}, 32'h0);

    // 6: LW at 0x2 -- trapped, or rounded down to a word read at 0x0.
`ifdef MISALIGN_TRAP_EN
    applyStimulus(1'b1, 32'h0000_0002, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 5'd8);
    #1;
    checkOutput("mis_stall", {31'h0, stall_out}, 32'h0);
    checkOutput("mis_req", {31'h0, dmem_req}, 32'h0);
    tick;
    ex_valid = 1'b0;
    checkOutput("mis_trap", {31'h0, misalign_trap}, 32'h1);
    checkOutput("mis_wb_valid", {31'h0, wb_valid}, 32'h1);
    checkOutput("mis_regw", {31'h0, wb_reg_write}, 32'h0);
`else
    applyStimulus(1'b1, 32'h0000_0002, 32'h0, F3_LW, 1'b1, 1'b0, 1'b1, 5'd8);
    tick;
    #1;
    checkOutput("mis_addr", dmem_addr, 32'h0000_0000);
    checkOutput("mis_be", {28'h0, dmem_be}, 32'hF);
    busLoadTail();
    checkOutput("mis_data", wb_memory_read, 32'h1122_3344);
    checkOutput("mis_trap", {31'h0, misalign_trap}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Completes a load already sitting in REQ: grant, then data next cycle.
  task automatic busLoadTail;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1122_3344;
    tick;
    dmem_rvalid = 1'b0;
    ex_valid    = 1'b0;
  endtask

endmodule
